// File: rtl/store_merge_unit_pkg.sv
// rtl/store_merge_unit_pkg.sv - shared store op codes, FSM encodings and align mask
// Purpose: definitions shared by the store merge unit, its lane merger and the
//          load data interface (store codes match the load size codes).
// Ports:   none (package).
package store_merge_unit_pkg;

  localparam logic [5:0]  OP_SB = 6'd0;
  localparam logic [5:0]  OP_SH = 6'd1;
  localparam logic [5:0]  OP_SW = 6'd2;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WRITE   = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  // Illegal ops and misaligned halves/words are rejected without touching memory.
  function automatic logic is_bad_store(input logic [5:0] op, input logic [1:0] addr_lo);
    logic bad;
    case (op)
      OP_SB:   bad = 1'b0;
      OP_SH:   bad = addr_lo[0];
      OP_SW:   bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// rtl/store_merge_unit_lane_merge.sv - combinational store lane merger
// Purpose: places store data into the addressed lanes of an existing word.
// Ports:   op       - store op code (SB/SH/SW, others leave word untouched)
//          addr_lo  - byte address bits [1:0]
//          old_word - word currently in memory
//          new_data - register data (low byte/half used for SB/SH)
//          merged   - resulting word
//          be       - lanes replaced
module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged,
  output logic [3:0]  be
);

  always_comb begin
    merged = old_word;
    be     = 4'b0000;
    case (op)
      OP_SB: begin
        be = 4'b0001 << addr_lo;
        case (addr_lo)
          2'd0:    merged[7:0]   = new_data[7:0];
          2'd1:    merged[15:8]  = new_data[7:0];
          2'd2:    merged[23:16] = new_data[7:0];
          default: merged[31:24] = new_data[7:0];
        endcase
      end
      OP_SH: begin
        if (addr_lo[1]) begin
          be             = 4'b1100;
          merged[31:16]  = new_data[15:0];
        end else begin
          be             = 4'b0011;
          merged[15:0]   = new_data[15:0];
        end
      end
      OP_SW: begin
        be     = 4'b1111;
        merged = new_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - store request to full-word memory write (read-modify-write for SB/SH)
// Purpose: accepts a store, reads the target word for sub-word stores, merges
//          and writes back a full word; stalls the requester until done.
// Ports:   clk, rst_n                         - clock, async active-low reset
//          st_valid/st_ready/st_op/st_addr/st_data - store request handshake
//          mem_addr, mem_rd_en, mem_rd_data, mem_rd_valid - word read port
//          mem_wr_en, mem_wr_data, mem_wr_be  - word write port
//          st_done, st_err                    - completion / error pulses
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int RD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [5:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_be,
  output logic        st_done,
  output logic        st_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(RD_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] wr_data_q;
  logic [3:0]  wr_be_q;
  logic [7:0]  cnt_q;
  logic [31:0] merged_word;
  logic [3:0]  merged_be;

  store_lane_merge u_merge (
    .op       (op_q),
    .addr_lo  (addr_q[1:0]),
    .old_word (mem_rd_data),
    .new_data (data_q),
    .merged   (merged_word),
    .be       (merged_be)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    st_ready  = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    st_done   = 1'b0;
    st_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        st_ready = 1'b1;
        if (st_valid) begin
          if (is_bad_store(st_op, st_addr[1:0])) state_nxt = ST_ERR;
          else if (st_op == OP_SW)                state_nxt = ST_WRITE;
          else                                    state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        mem_rd_en = 1'b1;
        // Zero-latency memories answer in the request cycle.
        state_nxt = mem_rd_valid ? ST_WRITE : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_rd_valid)               state_nxt = ST_WRITE;
        else if (cnt_q == TIMEOUT_LAST) state_nxt = ST_ERR;
      end
      ST_WRITE: begin
        mem_wr_en = 1'b1;
        st_done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        st_done   = 1'b1;
        st_err    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write data/enables live in their own registers so they hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (st_valid) begin
            op_q   <= st_op;
            addr_q <= st_addr;
            data_q <= st_data;
            if (st_op == OP_SW && st_addr[1:0] == 2'b00) begin
              wr_data_q <= st_data;
              wr_be_q   <= 4'b1111;
            end
          end
        end
        ST_RD_REQ: begin
          cnt_q <= '0;
          if (mem_rd_valid) begin
            wr_data_q <= merged_word;
            wr_be_q   <= merged_be;
          end
        end
        ST_RD_WAIT: begin
          if (mem_rd_valid) begin
            wr_data_q <= merged_word;
            wr_be_q   <= merged_be;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr    = addr_q & WORD_ALIGN_MASK;
  assign mem_wr_data = wr_data_q;
  assign mem_wr_be   = wr_be_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - scoreboard bench for store_merge_unit
module tb_store_merge_unit;

  localparam int RD_TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [5:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic        st_done;
  logic        st_err;

  always #5 clk = ~clk;

  store_merge_unit #(.RD_TIMEOUT(RD_TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_op        (st_op),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_be    (mem_wr_be),
    .st_done      (st_done),
    .st_err       (st_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    int          nrd;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   rd_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_merge(input logic [5:0] op, input logic [1:0] a,
                                            input logic [31:0] old, input logic [31:0] d);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    if (op == 6'd2) return d;
    if (op == 6'd0) b[a] = d[7:0];
    if (op == 6'd1) begin
      b[a]     = d[7:0];
      b[a + 1] = d[15:8];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [1:0] a);
    case (op)
      6'd0:    return 4'b0001 << a;
      6'd1:    return a[1] ? 4'hC : 4'h3;
      6'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_seen = 0;
    end else begin
      if (mem_wr_en && !st_done) chk("wr_without_done", 1, 0);
      if (mem_rd_en) begin
        rd_seen++;
        if (sb.size() > 0) chk("rd_addr", mem_addr, sb[0].addr);
      end
      if (st_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("err", 32'(st_err), 32'(e.err));
          chk("wr_en", 32'(mem_wr_en), 32'(!e.err));
          if (!e.err) begin
            chk("wr_addr", mem_addr, e.addr);
            chk("wr_data", mem_wr_data, e.wdata);
            chk("wr_be", 32'(mem_wr_be), 32'(e.be));
          end
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("rd_count", rd_seen, e.nrd);
        end
        rd_seen = 0;
      end
    end
  end

  // k = read wait cycles before data (0 = same cycle as request, <0 = never).
  // Called at a negedge with the unit idle; returns at the first idle negedge.
  task automatic run_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input int k, input logic [31:0] word);
    exp_t e;
    logic ill;
    logic sub;
    bit   done;
    ill = (op > 6'd2) || (op == 6'd1 && addr[0]) || (op == 6'd2 && addr[1:0] != 2'b00);
    sub = !ill && op != 6'd2;
    e.addr  = {addr[31:2], 2'b00};
    e.wdata = ref_merge(op, addr[1:0], word, data);
    e.be    = ref_be(op, addr[1:0]);
    e.err   = ill || (sub && k < 0);
    e.lat   = !sub ? 1 : (k < 0 ? 2 + RD_TO : 2 + k);
    e.nrd   = sub ? 1 : 0;
    e.acc   = cyc + 1;
    chk("ready_before_req", 32'(st_ready), 1);
    sb.push_back(e);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = addr;
    st_data  = data;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    st_op    = 6'($urandom);
    st_addr  = $urandom;
    st_data  = $urandom;
    if (sub && k >= 0) begin
      for (int i = 0; i < k; i++) begin
        @(posedge clk);
        #1;
      end
      mem_rd_valid = 1'b1;
      mem_rd_data  = word;
      @(posedge clk);
      #1;
      mem_rd_valid = 1'b0;
      mem_rd_data  = $urandom;
    end
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (st_ready) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    st_valid     = 1'b0;
    st_op        = '0;
    st_addr      = '0;
    st_data      = '0;
    mem_rd_data  = '0;
    mem_rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(st_ready), 1);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_done", 32'(st_done), 0);
    chk("rst_err", 32'(st_err), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_wr_be", 32'(mem_wr_be), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_store(6'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    run_store(6'd0, 32'h203, 32'h000000AB, 3, 32'h11223344);
    run_store(6'd1, 32'h302, 32'h0000CAFE, 0, 32'h55667788);
    run_store(6'd1, 32'h401, 32'h12345678, 0, 32'h0);
    run_store(6'd2, 32'h402, 32'h12345678, 0, 32'h0);
    run_store(6'd5, 32'h400, 32'h12345678, 0, 32'h0);

    // Read never answers: timeout, then a late response while idle is dropped.
    run_store(6'd0, 32'h500, 32'h00000012, -1, 32'h0);
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hFFFFFFFF;
    @(negedge clk);
    chk("late_ready", 32'(st_ready), 1);
    mem_rd_valid = 1'b0;
    @(negedge clk);
    chk("late_ready2", 32'(st_ready), 1);

    // Reset in RD_WAIT: straight back to idle, nothing written, no done.
    st_valid = 1'b1;
    st_op    = 6'd0;
    st_addr  = 32'h601;
    st_data  = 32'h55;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(st_ready), 1);
    chk("midrst_rd_en", 32'(mem_rd_en), 0);
    chk("midrst_wr_en", 32'(mem_wr_en), 0);
    chk("midrst_done", 32'(st_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 32'(st_ready), 1);
    run_store(6'd2, 32'h700, 32'hA5A5F00F, 0, 32'h0);

    // Back-to-back random mix.
    for (int n = 0; n < 24; n++) begin
      logic [5:0] op;
      int         sel;
      sel = $urandom_range(0, 7);
      op  = (sel < 7) ? 6'(sel % 3) : 6'($urandom_range(3, 63));
      run_store(op, $urandom, $urandom, $urandom_range(0, 4), $urandom);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
